// File: rtl/double_to_pcm16_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : double_to_pcm16_tx_pkg
// Description : Shared definitions for the double <-> PCM16 converters:
//               IEEE-754 field layout, PCM16 limits, state encoding and the
//               ties-to-even rounding helper.
// Revision    : 1.0 - initial release
// ============================================================================
package double_to_pcm16_tx_pkg;

    localparam int DBL_W      = 64;
    localparam int DBL_FRAC_W = 52;
    localparam int DBL_EXP_W  = 11;
    localparam int DBL_BIAS   = 1023;
    localparam int E_SPECIAL  = 2047;
    localparam int PCM_W      = 16;

    localparam logic [PCM_W-1:0] PCM16_MAX = 16'h7FFF;   //  32767
    localparam logic [PCM_W-1:0] PCM16_MIN = 16'h8000;   // -32768

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ROUND  = 3'd3,
        ST_SAT    = 3'd4,
        ST_TX     = 3'd5
    } state_e;

    // Outcome class of a conversion; only CAT_NUM uses the rounded magnitude.
    typedef enum logic [2:0] {
        CAT_NUM  = 3'd0,
        CAT_ZERO = 3'd1,
        CAT_NAN  = 3'd2,
        CAT_SAT  = 3'd3,
        CAT_MIN  = 3'd4
    } cat_e;

    // Ties-to-even: round up when guard is set and either the discarded tail
    // is non-zero or the kept integer is odd. Result is 17 bits wide.
    function automatic logic [PCM_W:0] round_te(input logic [PCM_W-1:0] int_part,
                                                 input logic guard,
                                                 input logic sticky);
        logic inc;
        inc = guard & (sticky | int_part[0]);
        return {1'b0, int_part} + {{PCM_W{1'b0}}, inc};
    endfunction

endpackage
`default_nettype wire

// File: rtl/double_to_pcm16_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : double_to_pcm16_tx_if
// Description : Handshake, data and serial-line bundle of the converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface double_to_pcm16_tx_if;
    import double_to_pcm16_tx_pkg::*;

    logic             enable;
    logic [DBL_W-1:0] double;
    logic [PCM_W-1:0] sig16b;
    logic             ready;
    logic             overflow;
    logic             busy;
    logic             dropped;
    logic             tx_data;
    logic             tx_frame;
    logic             tx_valid;

    modport master (
        output enable, double,
        input  sig16b, ready, overflow, busy, dropped, tx_data, tx_frame, tx_valid
    );

    modport slave (
        input  enable, double,
        output sig16b, ready, overflow, busy, dropped, tx_data, tx_frame, tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/double_to_pcm16_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : pcm16_serializer
// Description : Shifts a 16-bit word out MSB-first, each bit held BIT_DIV
//               cycles; frame marks bit 15, done flags the last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pcm16_serializer #(
    parameter int BIT_DIV = 4
) (
    input  logic        clk_operation,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] word_i,
    output logic        tx_data_o,
    output logic        tx_frame_o,
    output logic        tx_valid_o,
    output logic        done_o
);
    localparam int               DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

    logic [15:0]      shreg_q;
    logic [3:0]       bit_q;
    logic [DIV_W-1:0] div_q;
    logic             valid_q;
    logic             w_bit_end;

    assign w_bit_end  = valid_q && (div_q == DIV_LAST);
    assign done_o     = w_bit_end && (bit_q == 4'd15);
    assign tx_data_o  = valid_q & shreg_q[15];
    assign tx_frame_o = valid_q && (bit_q == 4'd0);
    assign tx_valid_o = valid_q;

    // Bit-period divider and shift register; a load restarts the frame.
    always_ff @(posedge clk_operation) begin
        if (!rst) begin
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            shreg_q <= word_i;
            bit_q   <= '0;
            div_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q) begin
            if (w_bit_end) begin
                div_q <= '0;
                if (bit_q == 4'd15) begin
                    valid_q <= 1'b0;
                    shreg_q <= '0;
                    bit_q   <= '0;
                end else begin
                    bit_q   <= bit_q + 4'd1;
                    shreg_q <= {shreg_q[14:0], 1'b0};
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/double_to_pcm16_tx.sv
`default_nettype none
// ============================================================================
// Module      : double_to_pcm16_tx
// Description : Converts one IEEE-754 double per request into saturated,
//               ties-to-even rounded PCM16 and ships it on a framed serial line.
// Revision    : 1.0 - initial release
// ============================================================================
module double_to_pcm16_tx
    import double_to_pcm16_tx_pkg::*;
#(
    parameter int SCALE_EXP = 0,
    parameter int BIT_DIV   = 4
) (
    input  logic                 clk_operation,
    input  logic                 rst,
    double_to_pcm16_tx_if.slave  bus
);
    localparam logic signed [12:0] SCALE_E13 = 13'(SCALE_EXP);
    localparam logic signed [12:0] BIAS_E13  = 13'(DBL_BIAS);

    state_e            state_q, state_d;
    logic [DBL_W-1:0]  dbl_q;
    cat_e              cat_q;
    logic signed [12:0] exp_q;
    logic [PCM_W-1:0]  int_q;
    logic              guard_q, sticky_q;
    logic [PCM_W:0]    mag_q;
    logic [PCM_W-1:0]  sig_q, sig_d;
    logic              ovf_q, ovf_d;
    logic              ready_q, dropped_q;
    logic              load;
    logic              w_ser_done;

    // Field split of the captured sample.
    logic                  w_sign;
    logic [DBL_EXP_W-1:0]  w_exp_raw;
    logic [DBL_FRAC_W-1:0] w_frac;
    logic signed [12:0]    w_exp_unb;
    logic [5:0]            w_sh;
    logic [106:0]          w_shift_src;
    logic [69:0]           w_shifted;

    assign w_sign    = dbl_q[DBL_W-1];
    assign w_exp_raw = dbl_q[DBL_W-2 -: DBL_EXP_W];
    assign w_frac    = dbl_q[DBL_FRAC_W-1:0];
    assign w_exp_unb = $signed({2'b00, w_exp_raw}) - BIAS_E13 + SCALE_E13;

    // Integer part sits at [69:54], guard at [53], sticky below. Only
    // e in -1..14 reaches here, so the shift is 38..53 and no bit is lost.
    assign w_sh        = 6'd52 - exp_q[5:0];
    assign w_shift_src = {1'b1, w_frac, 54'd0};
    assign w_shifted   = 70'(w_shift_src >> w_sh);

    // Conversion FSM: state register.
    always_ff @(posedge clk_operation) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Conversion FSM: next state and serializer load.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE:   if (bus.enable) state_d = ST_UNPACK;
            ST_UNPACK: state_d = ST_ALIGN;
            ST_ALIGN:  state_d = ST_ROUND;
            ST_ROUND:  state_d = ST_SAT;
            ST_SAT: begin
                state_d = ST_TX;
                load    = 1'b1;
            end
            ST_TX:     if (w_ser_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Final sample selection: specials, saturation or signed magnitude.
    always_comb begin
        sig_d = '0;
        ovf_d = 1'b0;
        case (cat_q)
            CAT_NAN: ovf_d = 1'b1;
            CAT_SAT: begin
                sig_d = w_sign ? PCM16_MIN : PCM16_MAX;
                ovf_d = 1'b1;
            end
            CAT_MIN: sig_d = PCM16_MIN;
            CAT_NUM: begin
                if (!w_sign && (mag_q > {1'b0, PCM16_MAX})) begin
                    sig_d = PCM16_MAX;
                    ovf_d = 1'b1;
                end else if (w_sign && (mag_q > {1'b0, PCM16_MIN})) begin
                    sig_d = PCM16_MIN;
                    ovf_d = 1'b1;
                end else begin
                    sig_d = w_sign ? (~mag_q[PCM_W-1:0] + 16'd1) : mag_q[PCM_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, advanced one pipeline step per FSM state.
    always_ff @(posedge clk_operation) begin
        if (!rst) begin
            dbl_q     <= '0;
            cat_q     <= CAT_NUM;
            exp_q     <= '0;
            int_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            mag_q     <= '0;
            sig_q     <= '0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            if (bus.enable && (state_q != ST_IDLE)) dropped_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) begin
                        dbl_q   <= bus.double;
                        ready_q <= 1'b0;
                    end
                end
                ST_UNPACK: begin
                    exp_q <= w_exp_unb;
                    if (w_exp_raw == '0)
                        cat_q <= CAT_ZERO;
                    else if (w_exp_raw == DBL_EXP_W'(E_SPECIAL))
                        cat_q <= (w_frac != '0) ? CAT_NAN : CAT_SAT;
                    else
                        cat_q <= CAT_NUM;
                end
                ST_ALIGN: begin
                    if (cat_q == CAT_NUM) begin
                        if (exp_q < -13'sd1)
                            cat_q <= CAT_ZERO;
                        else if (exp_q > 13'sd14)
                            cat_q <= (w_sign && (exp_q == 13'sd15) && (w_frac == '0))
                                     ? CAT_MIN : CAT_SAT;
                    end
                    int_q    <= w_shifted[69:54];
                    guard_q  <= w_shifted[53];
                    sticky_q <= |w_shifted[52:0];
                end
                ST_ROUND: mag_q <= round_te(int_q, guard_q, sticky_q);
                ST_SAT: begin
                    sig_q   <= sig_d;
                    ovf_q   <= ovf_d;
                    ready_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    pcm16_serializer #(
        .BIT_DIV (BIT_DIV)
    ) u_ser (
        .clk_operation (clk_operation),
        .rst           (rst),
        .load_i        (load),
        .word_i        (sig_d),
        .tx_data_o     (bus.tx_data),
        .tx_frame_o    (bus.tx_frame),
        .tx_valid_o    (bus.tx_valid),
        .done_o        (w_ser_done)
    );

    assign bus.sig16b   = sig_q;
    assign bus.overflow = ovf_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.dropped  = dropped_q;
endmodule
`default_nettype wire

// File: tb/tb_double_to_pcm16_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_double_to_pcm16_tx
// Description : Self-checking bench: directed ties/saturation/special cases,
//               random samples against a real-arithmetic reference, dropped
//               enable, back-to-back transfers and reset mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_double_to_pcm16_tx;

    logic clk_operation = 1'b0;
    logic rst;
    always #5 clk_operation = ~clk_operation;

    double_to_pcm16_tx_if bus0();
    double_to_pcm16_tx_if bus15();

    double_to_pcm16_tx #(.SCALE_EXP(0), .BIT_DIV(4)) u_dut0 (
        .clk_operation (clk_operation),
        .rst           (rst),
        .bus           (bus0)
    );

    double_to_pcm16_tx #(.SCALE_EXP(15), .BIT_DIV(1)) u_dut15 (
        .clk_operation (clk_operation),
        .rst           (rst),
        .bus           (bus15)
    );

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic exp_drop0    = 1'b0;
    logic exp_drop15   = 1'b0;

    // Reference: round(x * 2^scale) ties-to-even, saturating; |v| >= 2^15 is
    // out of range except exactly -32768; NaN gives 0 with overflow.
    function automatic void model(input logic [63:0] d, input int scale,
                                  output logic [15:0] r, output logic o);
        real v, fl, fr;
        int  n;
        if (d[62:52] == 11'h7FF) begin
            o = 1'b1;
            r = (d[51:0] != 0) ? 16'h0000 : (d[63] ? 16'h8000 : 16'h7FFF);
            return;
        end
        v = $bitstoreal(d);
        for (int k = 0; k < scale; k++)  v = v * 2.0;
        for (int k = 0; k < -scale; k++) v = v / 2.0;
        if (v >= 32768.0) begin
            r = 16'h7FFF; o = 1'b1;
        end else if (v < -32768.0) begin
            r = 16'h8000; o = 1'b1;
        end else begin
            fl = $floor(v);
            fr = v - fl;
            n  = $rtoi(fl);
            if (fr > 0.5 || (fr == 0.5 && (n % 2) != 0)) n = n + 1;
            if (n > 32767) begin
                r = 16'h7FFF; o = 1'b1;
            end else begin
                r = n[15:0]; o = 1'b0;
            end
        end
    endfunction

    function automatic logic [63:0] rand_double(input int scale);
        logic [63:0] r;
        real         v;
        int          k;
        case ($urandom_range(0, 2))
            0: begin
                k = int'($urandom_range(0, 200000)) - 100000;
                v = $itor(k) / 4.0;
                for (int j = 0; j < scale; j++) v = v / 2.0;
                r = $realtobits(v);
            end
            1: begin
                r = {$urandom, $urandom};
                r[62:52] = 11'(1019 - scale + int'($urandom_range(0, 20)));
            end
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    // One full conversion plus frame; enable is driven as soon as the DUT is
    // idle, so consecutive calls run at the minimum enable spacing.
    task automatic run_conv(virtual double_to_pcm16_tx_if vif, input int bdiv,
                            input logic [63:0] d, input logic [15:0] exp_r,
                            input logic exp_o, input int drop_at,
                            input string nm, inout logic exp_drop);
        int   wait_cyc;
        int   ser_err;
        logic early;
        wait_cyc = 0;
        while (vif.busy !== 1'b0 && wait_cyc < 200) begin
            @(posedge clk_operation); #1;
            wait_cyc++;
        end
        if (wait_cyc >= 200) begin
            tests_run++; tests_failed++;
            $display("FAIL %s idle_timeout busy=%b required 0", nm, vif.busy);
            return;
        end
        vif.enable = 1'b1;
        vif.double = d;
        @(posedge clk_operation); #1;
        vif.enable = 1'b0;
        vif.double = {$urandom, $urandom};
        tests_run++;
        if (vif.busy !== 1'b1 || vif.ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s accept busy=%b ready=%b required 1 0", nm, vif.busy, vif.ready);
        end
        early = 1'b0;
        repeat (3) begin
            @(posedge clk_operation); #1;
            if (vif.ready !== 1'b0) early = 1'b1;
        end
        @(posedge clk_operation); #1;
        tests_run++;
        if (early || vif.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_latency early=%b ready=%b required 0 1", nm, early, vif.ready);
        end
        tests_run++;
        if (vif.sig16b !== exp_r || vif.overflow !== exp_o) begin
            tests_failed++;
            $display("FAIL %s value d=%h sig16b=%h ovf=%b required %h %b",
                     nm, d, vif.sig16b, vif.overflow, exp_r, exp_o);
        end
        ser_err = 0;
        for (int i = 0; i < 16 * bdiv; i++) begin
            if (vif.tx_valid !== 1'b1 || vif.tx_data !== exp_r[15 - i / bdiv] ||
                vif.tx_frame !== (i < bdiv))
                ser_err++;
            vif.enable = (i == drop_at);
            if (i == drop_at) exp_drop = 1'b1;
            @(posedge clk_operation); #1;
        end
        vif.enable = 1'b0;
        tests_run++;
        if (ser_err != 0) begin
            tests_failed++;
            $display("FAIL %s serial bad_cycles=%0d required 0 word=%h", nm, ser_err, exp_r);
        end
        tests_run++;
        if ({vif.tx_valid, vif.tx_frame, vif.tx_data, vif.busy} !== 4'b0000 ||
            vif.ready !== 1'b1 || vif.sig16b !== exp_r) begin
            tests_failed++;
            $display("FAIL %s end_of_frame valid=%b frame=%b data=%b busy=%b ready=%b sig=%h required 0 0 0 0 1 %h",
                     nm, vif.tx_valid, vif.tx_frame, vif.tx_data, vif.busy, vif.ready, vif.sig16b, exp_r);
        end
        tests_run++;
        if (vif.dropped !== exp_drop) begin
            tests_failed++;
            $display("FAIL %s dropped=%b required %b", nm, vif.dropped, exp_drop);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus0.enable  = 1'b0; bus0.double  = '0;
        bus15.enable = 1'b0; bus15.double = '0;
        repeat (3) @(posedge clk_operation);
        #1;
        tests_run++;
        if ({bus0.sig16b, bus0.ready, bus0.overflow, bus0.busy, bus0.dropped,
             bus0.tx_data, bus0.tx_frame, bus0.tx_valid} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_dut0 sig=%h rdy=%b busy=%b valid=%b required all 0",
                     bus0.sig16b, bus0.ready, bus0.busy, bus0.tx_valid);
        end
        tests_run++;
        if ({bus15.sig16b, bus15.ready, bus15.overflow, bus15.busy, bus15.dropped,
             bus15.tx_data, bus15.tx_frame, bus15.tx_valid} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_dut15 sig=%h rdy=%b busy=%b valid=%b required all 0",
                     bus15.sig16b, bus15.ready, bus15.busy, bus15.tx_valid);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        run_conv(bus0, 4, 64'h4008000000000000, 16'h0003, 1'b0, -1, "basic_3p0", exp_drop0);
    endtask

    task automatic test_ties();
        run_conv(bus0, 4, $realtobits(2.5),  16'h0002, 1'b0, -1, "tie_2p5",  exp_drop0);
        run_conv(bus0, 4, $realtobits(3.5),  16'h0004, 1'b0, -1, "tie_3p5",  exp_drop0);
        run_conv(bus0, 4, $realtobits(-2.5), 16'hFFFE, 1'b0, -1, "tie_m2p5", exp_drop0);
        run_conv(bus0, 4, $realtobits(0.5),  16'h0000, 1'b0, -1, "tie_0p5",  exp_drop0);
        run_conv(bus0, 4, $realtobits(0.75), 16'h0001, 1'b0, -1, "tie_0p75", exp_drop0);
    endtask

    task automatic test_saturation();
        run_conv(bus0, 4, $realtobits(40000.0),  16'h7FFF, 1'b1, -1, "sat_40000",  exp_drop0);
        run_conv(bus0, 4, $realtobits(32767.5),  16'h7FFF, 1'b1, -1, "sat_32767p5", exp_drop0);
        run_conv(bus0, 4, $realtobits(-32768.0), 16'h8000, 1'b0, -1, "min_exact",  exp_drop0);
        run_conv(bus0, 4, $realtobits(-1.0e6),   16'h8000, 1'b1, -1, "sat_m1e6",   exp_drop0);
        run_conv(bus0, 4, 64'h7FF0000000000000,  16'h7FFF, 1'b1, -1, "pos_inf",    exp_drop0);
        run_conv(bus0, 4, 64'h7FF8000000000000,  16'h0000, 1'b1, -1, "nan",        exp_drop0);
    endtask

    task automatic test_specials();
        run_conv(bus0, 4, 64'h0000000000000000, 16'h0000, 1'b0, -1, "pos_zero",  exp_drop0);
        run_conv(bus0, 4, 64'h8000000000000000, 16'h0000, 1'b0, -1, "neg_zero",  exp_drop0);
        run_conv(bus0, 4, 64'h0000000000000001, 16'h0000, 1'b0, -1, "subnormal", exp_drop0);
        run_conv(bus15, 1, $realtobits(0.5),  16'h4000, 1'b0, -1, "s15_0p5",  exp_drop15);
        run_conv(bus15, 1, $realtobits(-1.0), 16'h8000, 1'b0, -1, "s15_m1p0", exp_drop15);
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic [15:0] r;
        logic        o;
        for (int n = 0; n < 30; n++) begin
            d = rand_double(0);
            model(d, 0, r, o);
            run_conv(bus0, 4, d, r, o, -1, "rand_s0", exp_drop0);
        end
        for (int n = 0; n < 20; n++) begin
            d = rand_double(15);
            model(d, 15, r, o);
            run_conv(bus15, 1, d, r, o, -1, "rand_s15", exp_drop15);
        end
    endtask

    task automatic test_dropped();
        run_conv(bus0, 4, $realtobits(-12345.0), 16'hCFC7, 1'b0, 10, "drop_in_tx", exp_drop0);
        run_conv(bus0, 4, $realtobits(1234.25),  16'h04D2, 1'b0, -1, "after_drop", exp_drop0);
    endtask

    task automatic test_back_to_back();
        run_conv(bus0, 4, $realtobits(-7.5),  16'hFFF8, 1'b0, -1, "b2b_a", exp_drop0);
        run_conv(bus0, 4, $realtobits(100.5), 16'h0064, 1'b0, -1, "b2b_b", exp_drop0);
        run_conv(bus0, 4, $realtobits(-0.49), 16'h0000, 1'b0, -1, "b2b_c", exp_drop0);
    endtask

    task automatic test_reset_mid_tx();
        bus0.enable = 1'b1;
        bus0.double = $realtobits(-12345.0);
        @(posedge clk_operation); #1;
        bus0.enable = 1'b0;
        repeat (4 + 7 * 4 + 1) @(posedge clk_operation);
        #1;
        tests_run++;
        if (bus0.tx_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_tx_active tx_valid=%b required 1", bus0.tx_valid);
        end
        rst = 1'b0;
        @(posedge clk_operation); #1;
        tests_run++;
        if ({bus0.sig16b, bus0.ready, bus0.overflow, bus0.busy, bus0.dropped,
             bus0.tx_data, bus0.tx_frame, bus0.tx_valid} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_tx sig=%h rdy=%b busy=%b drop=%b valid=%b required all 0",
                     bus0.sig16b, bus0.ready, bus0.busy, bus0.dropped, bus0.tx_valid);
        end
        rst = 1'b1;
        exp_drop0  = 1'b0;
        exp_drop15 = 1'b0;
        run_conv(bus0, 4, $realtobits(3.5), 16'h0004, 1'b0, -1, "after_reset", exp_drop0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_saturation();
        test_specials();
        test_random();
        test_dropped();
        test_back_to_back();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout tests_run=%0d", tests_run);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/double_to_pcm16_tx.md
Name: double_to_pcm16_tx

Overview:
- Output end of the echo-cancellation chain; the inverse of the 16-bit-to-double input converter.
- Accepts one IEEE-754 double per sampling period (echo-free signal or error `e`).
- Converts it to signed 16-bit PCM with ties-to-even rounding and saturation, then shifts the word out MSB-first on a framed serial line toward the codec.
- Uses the same pulse `enable` / level `ready` handshake as the other double-domain blocks.

Parameters:
- SCALE_EXP, 0: power-of-two gain applied before rounding; sample = round(x * 2^SCALE_EXP). Signed, range -16..16.
- BIT_DIV, 4: clk_operation cycles per serial bit, at least 1.

Ports:
- clk_operation  in   1   system clock; all logic on rising edge
- rst            in   1   synchronous, active-low reset
- enable         in   1   start pulse; sampled only in IDLE
- double         in   64  IEEE-754 input sample; captured on accepted enable
- sig16b         out  16  converted two's-complement sample; held until the next conversion
- ready          out  1   high from conversion complete until the next accepted enable
- overflow       out  1   last conversion saturated or was NaN; valid with ready
- busy           out  1   high in every state except IDLE
- dropped        out  1   sticky; set when enable arrives while busy; cleared only by reset
- tx_data        out  1   serial data, MSB first
- tx_frame       out  1   high during the BIT_DIV cycles of bit 15 only
- tx_valid       out  1   high while a bit is on tx_data

Behaviour:
- Reset (rst==0 at a clock edge) sets state IDLE and clears all outputs and internal registers to 0.
- Reset mid-conversion or mid-transmission aborts immediately; no partial frame is completed.
- States: IDLE -> UNPACK -> ALIGN -> ROUND -> SAT -> TX -> IDLE.
- IDLE: on enable==1, capture `double`, clear ready, go to UNPACK (cycle 0 = accept edge).
- UNPACK: split into s, E, F. Compute e = E - 1023 + SCALE_EXP in a 13-bit signed value.
  - E==0 (zero or subnormal): result 0, no overflow.
  - E==2047 with F!=0 (NaN): result 0, overflow=1.
  - E==2047 with F==0 (Inf): saturate by sign, overflow=1.
- ALIGN (used only when no special case applies):
  - e <= -2: magnitude 0.
  - e >= 15: saturate, except s=1, e==15, F==0, which gives -32768 with no overflow.
  - Otherwise shift {1,F} right so that the 16-bit integer part, guard bit and sticky bit are formed. One barrel shift, single cycle.
- ROUND: ties-to-even on (guard, sticky, lsb); magnitude is 17 bits wide.
- SAT:
  - Positive magnitude > 32767 gives 32767 with overflow=1.
  - Negative magnitude > 32768 gives -32768 with overflow=1.
  - Otherwise apply two's-complement negation if s=1.
  - Register sig16b and overflow, assert ready.
  - ready rises 4 cycles after the accept edge and stays high until the next accepted enable.
- TX: 16 bits, each held exactly BIT_DIV cycles.
  - Bit 15 first, with tx_frame=1.
  - tx_valid=1 for 16*BIT_DIV cycles, then state returns to IDLE and tx_* drop to 0.
  - Next enable is accepted on the first IDLE cycle, so back-to-back transfers have minimum enable spacing 5 + 16*BIT_DIV cycles.
- enable while busy: ignored, dropped set, current operation unaffected.
- Negative zero (-0.0) gives 0x0000.
- Input is never re-sampled after capture, so `double` may change during busy.

Decomposition:
- Shared package (same one the 16-bit-to-double converter uses):
  - double field widths and exponent bias 1023.
  - E_SPECIAL = 2047.
  - PCM16_MAX = 32767, PCM16_MIN = -32768.
  - State encoding.
- Sub-module pcm16_serializer: load pulse plus 16-bit word, generates tx_data, tx_frame, tx_valid, done using the BIT_DIV counter. The conversion FSM stays in the top.

Test Plan:
- 3.0 (0x4008000000000000), SCALE_EXP=0 -> sig16b=0x0003, overflow=0, ready 4 cycles after enable. Serial stream 0000000000000011, tx_frame high only on the first bit, 64 tx_valid cycles at BIT_DIV=4.
- Ties: 2.5 -> 0x0002; 3.5 -> 0x0004; -2.5 -> 0xFFFE; 0.5 -> 0x0000; 0.75 -> 0x0001.
- Saturation:
  - 40000.0 -> 0x7FFF, overflow=1.
  - 32767.5 -> 0x7FFF, overflow=1.
  - -32768.0 -> 0x8000, overflow=0.
  - -1e6 -> 0x8000, overflow=1.
  - +Inf -> 0x7FFF, overflow=1.
  - NaN -> 0x0000, overflow=1.
- Specials and scaling:
  - 0.0, -0.0 and the smallest subnormal all -> 0x0000.
  - SCALE_EXP=15: 0.5 -> 0x4000; -1.0 -> 0x8000, overflow=0.
- Handshake: enable pulsed during TX -> ignored, dropped=1, frame intact. Next enable accepted in IDLE produces a correct conversion.
- Reset mid-TX at bit 7 -> next edge all outputs 0, state IDLE. A new enable after rst=1 converts correctly.
